// File: rtl/scm_load_ctrl_if.sv
// Bundle of the LUT-load stream, the two-requester read port and the scm
// write/read connections around scm_load_ctrl.
interface scm_load_ctrl_if #(
   parameter int AddrWidth     = 9,
   parameter int DataTypeWidth = 16
);
   logic                     load_start;
   logic                     load_valid;
   logic [DataTypeWidth-1:0] load_data;
   logic                     load_ready;
   logic                     load_busy;
   logic                     load_done;
   logic [1:0]               rd_req;
   logic [2*AddrWidth-1:0]   rd_addr;
   logic [1:0]               rd_gnt;
   logic [1:0]               rd_valid;
   logic [DataTypeWidth-1:0] rd_data;
   logic [AddrWidth-1:0]     scm_raddr;
   logic [DataTypeWidth-1:0] scm_rdata;
   logic [AddrWidth-1:0]     scm_waddr;
   logic [DataTypeWidth-1:0] scm_wdata;
   logic                     scm_we;

   modport slave (
      input  load_start, load_valid, load_data, rd_req, rd_addr, scm_rdata,
      output load_ready, load_busy, load_done, rd_gnt, rd_valid, rd_data,
             scm_raddr, scm_waddr, scm_wdata, scm_we
   );

   modport master (
      output load_start, load_valid, load_data, rd_req, rd_addr, scm_rdata,
      input  load_ready, load_busy, load_done, rd_gnt, rd_valid, rd_data,
             scm_raddr, scm_waddr, scm_wdata, scm_we
   );
endinterface

// File: rtl/scm_load_ctrl.sv
// Load sequencer and round-robin read arbiter in front of one latch-based scm.
// Reads are only granted in IDLE, so scm writes and grants never overlap.
module scm_load_ctrl #(
   parameter int C              = 32,
   parameter int K              = 16,
   parameter int DataTypeWidth  = 16,
   parameter int ScmReadLatency = 1,
   parameter int DrainCycles    = 2
) (
   input logic              clk,
   input logic              rst_n,
   scm_load_ctrl_if.slave   bus
);
   localparam int Depth     = C * K;
   localparam int AddrWidth = $clog2(Depth);
   localparam int CntW      = AddrWidth + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_LOAD  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   localparam logic [CntW-1:0] CNT_ZERO   = {CntW{1'b0}};
   localparam logic [CntW-1:0] CNT_ONE    = CntW'(1);
   localparam logic [CntW-1:0] LAST_BEAT  = CntW'(Depth - 1);
   localparam logic [CntW-1:0] DRAIN_LAST = CntW'(DrainCycles - 1);

   logic [1:0]      state_r;
   logic [1:0]      state_nxt_s;
   logic [CntW-1:0] cnt_r;
   logic [CntW-1:0] cnt_nxt_s;
   logic            done_r;
   logic            done_nxt_s;
   logic            ptr_r;
   logic            ptr_nxt_s;
   logic            beat_s;
   logic            arb_en_s;
   logic [1:0]      gnt_s;
   logic [1:0]      vld_s;

   // FSM next state and shared write/drain counter
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      done_nxt_s  = 1'b0;
      beat_s      = (state_r == ST_LOAD) && bus.load_valid;
      case (state_r)
         ST_IDLE: begin
            if (bus.load_start) begin
               state_nxt_s = ST_LOAD;
               cnt_nxt_s   = CNT_ZERO;
            end else begin
               cnt_nxt_s   = cnt_r;
            end
         end
         ST_LOAD: begin
            if (beat_s && (cnt_r == LAST_BEAT)) begin
               state_nxt_s = ST_DRAIN;
               cnt_nxt_s   = CNT_ZERO;
            end else if (beat_s) begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end else begin
               cnt_nxt_s   = cnt_r;
            end
         end
         ST_DRAIN: begin
            if (cnt_r == DRAIN_LAST) begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = CNT_ZERO;
               done_nxt_s  = 1'b1;
            end else begin
               cnt_nxt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // Round-robin grant: with both requesting, the one after the last winner wins
   always_comb begin
      arb_en_s  = rst_n && (state_r == ST_IDLE) && !bus.load_start;
      gnt_s     = 2'b00;
      ptr_nxt_s = ptr_r;
      if (arb_en_s) begin
         case (bus.rd_req)
            2'b01:   gnt_s = 2'b01;
            2'b10:   gnt_s = 2'b10;
            2'b11:   gnt_s = ptr_r ? 2'b01 : 2'b10;
            default: gnt_s = 2'b00;
         endcase
      end else begin
         gnt_s = 2'b00;
      end
      if (gnt_s[1]) begin
         ptr_nxt_s = 1'b1;
      end else if (gnt_s[0]) begin
         ptr_nxt_s = 1'b0;
      end else begin
         ptr_nxt_s = ptr_r;
      end
   end

   // Control state registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         done_r  <= 1'b0;
         ptr_r   <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         done_r  <= done_nxt_s;
         ptr_r   <= ptr_nxt_s;
      end
   end

   generate
      if (ScmReadLatency == 0) begin : g_lat0
         assign vld_s = gnt_s;
      end else begin : g_latn
         logic [1:0] pipe_r [ScmReadLatency];

         // Grant delay line matching the scm read latency
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < ScmReadLatency; i++) begin
                  pipe_r[i] <= 2'b00;
               end
            end else begin
               pipe_r[0] <= gnt_s;
               for (int i = 1; i < ScmReadLatency; i++) begin
                  pipe_r[i] <= pipe_r[i-1];
               end
            end
         end

         assign vld_s = pipe_r[ScmReadLatency-1];
      end
   endgenerate

   // Outputs are forced low while reset is asserted, even mid-load.
   assign bus.load_ready = rst_n && (state_r == ST_LOAD);
   assign bus.load_busy  = rst_n && ((state_r == ST_LOAD) || (state_r == ST_DRAIN));
   assign bus.load_done  = rst_n && done_r;
   assign bus.scm_we     = rst_n && beat_s;
   assign bus.scm_waddr  = bus.scm_we ? cnt_r[AddrWidth-1:0] : {AddrWidth{1'b0}};
   assign bus.scm_wdata  = bus.scm_we ? bus.load_data : {DataTypeWidth{1'b0}};
   assign bus.rd_gnt     = gnt_s;
   assign bus.scm_raddr  = gnt_s[1] ? bus.rd_addr[AddrWidth +: AddrWidth] :
                           gnt_s[0] ? bus.rd_addr[0 +: AddrWidth] : {AddrWidth{1'b0}};
   assign bus.rd_valid   = rst_n ? vld_s : 2'b00;
   assign bus.rd_data    = (|bus.rd_valid) ? bus.scm_rdata : {DataTypeWidth{1'b0}};
endmodule

// File: tb/tb_scm_load_ctrl.sv
// Directed bench for scm_load_ctrl with a behavioural one-cycle-latency scm.
module tb_scm_load_ctrl;
   localparam int AW = 9;
   localparam int DW = 16;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   busy_cycles;
   int   done_cnt;

   logic [DW-1:0] scm_mem [0:511];
   logic [DW-1:0] scm_rdata_r;
   logic [DW-1:0] exp_mem [0:511];
   logic [1:0]    prev_gnt;
   logic [AW-1:0] prev_addr;
   logic [1:0]    exp_gnt;
   logic [AW-1:0] exp_addr;
   int            b0;
   int            d0;

   scm_load_ctrl_if #(.AddrWidth(AW), .DataTypeWidth(DW)) bus ();

   scm_load_ctrl #(
      .C(32), .K(16), .DataTypeWidth(DW), .ScmReadLatency(1), .DrainCycles(2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.scm_we) scm_mem[bus.scm_waddr] <= bus.scm_wdata;
      scm_rdata_r <= scm_mem[bus.scm_raddr];
   end
   assign bus.scm_rdata = scm_rdata_r;

   always @(negedge clk) begin
      if (bus.load_busy) busy_cycles <= busy_cycles + 1;
      if (bus.load_done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_image(input logic [15:0] key, input bit toggle);
      int  idx;
      logic v;
      bus.load_start = 1'b1;
      #1;
      chk("start_busy", {31'd0, bus.load_busy}, 32'd0);
      tick();
      bus.load_start = 1'b0;
      b0  = busy_cycles;
      idx = 0;
      for (int k = 0; (idx < 512) && (k < 2000); k++) begin
         v = toggle ? k[0] : 1'b1;
         bus.load_valid = v;
         bus.load_data  = idx[15:0] ^ key;
         #1;
         chk("we", {31'd0, bus.scm_we}, {31'd0, v});
         chk("waddr", {23'd0, bus.scm_waddr}, v ? idx : 32'd0);
         chk("wdata", {16'd0, bus.scm_wdata}, v ? {16'd0, idx[15:0] ^ key} : 32'd0);
         chk("ready", {31'd0, bus.load_ready}, 32'd1);
         if (v) begin
            exp_mem[idx] = idx[15:0] ^ key;
            idx++;
         end
         tick();
      end
      bus.load_valid = 1'b0;
      bus.load_data  = 16'h0000;
      #1;
      chk("drain_ready", {31'd0, bus.load_ready}, 32'd0);
      chk("drain_we", {31'd0, bus.scm_we}, 32'd0);
      chk("drain_busy", {31'd0, bus.load_busy}, 32'd1);
      chk("drain_done", {31'd0, bus.load_done}, 32'd0);
      tick();
      tick();
      chk("done_pulse", {31'd0, bus.load_done}, 32'd1);
      chk("idle_busy", {31'd0, bus.load_busy}, 32'd0);
      chk("busy_len", busy_cycles - b0, toggle ? 32'd1026 : 32'd514);
   endtask

   initial begin
      checks = 0;
      failures = 0;
      busy_cycles = 0;
      done_cnt = 0;
      rst_n = 1'b0;
      bus.load_start = 1'b0;
      bus.load_valid = 1'b0;
      bus.load_data  = 16'h0000;
      bus.rd_req     = 2'b00;
      bus.rd_addr    = {AW{2'b00}};
      tick();
      tick();
      bus.rd_req = 2'b11;
      #1;
      chk("rst_busy",  {31'd0, bus.load_busy},  32'd0);
      chk("rst_ready", {31'd0, bus.load_ready}, 32'd0);
      chk("rst_done",  {31'd0, bus.load_done},  32'd0);
      chk("rst_gnt",   {30'd0, bus.rd_gnt},     32'd0);
      chk("rst_valid", {30'd0, bus.rd_valid},   32'd0);
      chk("rst_raddr", {23'd0, bus.scm_raddr},  32'd0);
      chk("rst_waddr", {23'd0, bus.scm_waddr},  32'd0);
      chk("rst_wdata", {16'd0, bus.scm_wdata},  32'd0);
      chk("rst_rdata", {16'd0, bus.rd_data},    32'd0);
      bus.rd_req = 2'b00;
      rst_n = 1'b1;
      tick();

      // full-rate load, done exactly once
      d0 = done_cnt;
      load_image(16'hA5A5, 1'b0);
      tick();
      chk("done_once1", done_cnt - d0, 32'd1);
      chk("done_low", {31'd0, bus.load_done}, 32'd0);

      // half-rate load, then read the last entry in the done cycle
      d0 = done_cnt;
      load_image(16'h5A5A, 1'b1);
      bus.rd_req  = 2'b01;
      bus.rd_addr = {9'd0, 9'd511};
      #1;
      chk("last_gnt", {30'd0, bus.rd_gnt}, 32'd1);
      chk("last_raddr", {23'd0, bus.scm_raddr}, 32'd511);
      tick();
      chk("last_valid", {30'd0, bus.rd_valid}, 32'd1);
      chk("last_data", {16'd0, bus.rd_data}, {16'd0, 16'h01FF ^ 16'h5A5A});
      chk("done_once2", done_cnt - d0, 32'd1);

      // pointer to requester 1, then both requesting alternate 0,1,0,1
      bus.rd_req  = 2'b10;
      bus.rd_addr = {9'd300, 9'd5};
      #1;
      chk("single_gnt", {30'd0, bus.rd_gnt}, 32'd2);
      prev_gnt  = 2'b10;
      prev_addr = 9'd300;
      tick();
      bus.rd_req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         exp_gnt  = (k % 2 == 0) ? 2'b01 : 2'b10;
         exp_addr = (k % 2 == 0) ? 9'd5 : 9'd300;
         #1;
         chk("rr_gnt", {30'd0, bus.rd_gnt}, {30'd0, exp_gnt});
         chk("rr_raddr", {23'd0, bus.scm_raddr}, {23'd0, exp_addr});
         chk("rr_valid", {30'd0, bus.rd_valid}, {30'd0, prev_gnt});
         chk("rr_data", {16'd0, bus.rd_data}, {16'd0, exp_mem[prev_addr]});
         prev_gnt  = exp_gnt;
         prev_addr = exp_addr;
         tick();
      end

      // load start beats the read requests; the read in flight completes
      bus.load_start = 1'b1;
      #1;
      chk("ls_gnt", {30'd0, bus.rd_gnt}, 32'd0);
      chk("ls_raddr", {23'd0, bus.scm_raddr}, 32'd0);
      chk("ls_valid", {30'd0, bus.rd_valid}, {30'd0, prev_gnt});
      chk("ls_data", {16'd0, bus.rd_data}, {16'd0, exp_mem[prev_addr]});
      tick();
      bus.load_start = 1'b0;
      #1;
      chk("ls_busy", {31'd0, bus.load_busy}, 32'd1);
      chk("ls_nogrant", {30'd0, bus.rd_gnt}, 32'd0);
      chk("ls_valid_off", {30'd0, bus.rd_valid}, 32'd0);
      bus.rd_req = 2'b00;

      // abort at beat 200 with a one-cycle reset
      for (int i = 0; i < 200; i++) begin
         bus.load_valid = 1'b1;
         bus.load_data  = i[15:0] ^ 16'h1234;
         #1;
         chk("ab_waddr", {23'd0, bus.scm_waddr}, i);
         tick();
      end
      d0 = done_cnt;
      rst_n = 1'b0;
      bus.load_data = 16'hFFFF;
      #1;
      chk("ab_we", {31'd0, bus.scm_we}, 32'd0);
      chk("ab_waddr0", {23'd0, bus.scm_waddr}, 32'd0);
      chk("ab_wdata0", {16'd0, bus.scm_wdata}, 32'd0);
      chk("ab_ready", {31'd0, bus.load_ready}, 32'd0);
      chk("ab_busy", {31'd0, bus.load_busy}, 32'd0);
      tick();
      rst_n = 1'b1;
      bus.load_valid = 1'b0;
      bus.load_data  = 16'h0000;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("ab_idle_busy", {31'd0, bus.load_busy}, 32'd0);
         chk("ab_idle_done", {31'd0, bus.load_done}, 32'd0);
         tick();
      end
      chk("ab_no_done", done_cnt - d0, 32'd0);

      // a full load after the abort completes normally
      load_image(16'hA5A5, 1'b0);
      tick();
      bus.rd_req  = 2'b10;
      bus.rd_addr = {9'd200, 9'd0};
      #1;
      chk("post_gnt", {30'd0, bus.rd_gnt}, 32'd2);
      tick();
      bus.rd_req = 2'b00;
      chk("post_valid", {30'd0, bus.rd_valid}, 32'd2);
      chk("post_data", {16'd0, bus.rd_data}, {16'd0, 16'h00C8 ^ 16'hA5A5});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
